// File: rtl/mode_counter.sv
// mode_counter: sample-address generator. While enabled, cout advances by
// `mode` addresses per cycle through 0..LAST_ADDR. When the next step would
// pass LAST_ADDR, cout wraps to 0 (the remainder is dropped) and resetOut
// pulses high for one cycle. Both outputs are registered.
module mode_counter #(
  parameter int unsigned LAST_ADDR = 22499,
  parameter int unsigned WIDTH     = 15
) (
  input  logic             clk,
  input  logic             resetIn,
  input  logic [2:0]       mode,
  input  logic             enb,
  output logic             resetOut,
  output logic [WIDTH-1:0] cout
);

  // One extra bit so cout + 7 cannot overflow before the range compare.
  localparam int unsigned SumW = WIDTH + 1;

  logic [WIDTH-1:0] r_cout = '0;
  logic             r_wrap = 1'b0;

  logic [SumW-1:0]  w_sum;
  logic [WIDTH-1:0] w_cout_d;
  logic             w_wrap_d;
  logic             w_step_en;

  assign w_step_en = enb && (mode != 3'd0);
  assign w_sum     = {1'b0, r_cout} + SumW'(mode);

  // Next-state: hold when idle, otherwise step or wrap to 0 past LAST_ADDR.
  always_comb begin
    w_cout_d = r_cout;
    w_wrap_d = 1'b0;
    if (w_step_en) begin
      if (w_sum > SumW'(LAST_ADDR)) begin
        w_cout_d = '0;
        w_wrap_d = 1'b1;
      end else begin
        w_cout_d = w_sum[WIDTH-1:0];
      end
    end
  end

  // State register with synchronous reset taking priority over counting.
  always_ff @(posedge clk) begin
    if (resetIn) begin
      r_cout <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cout <= w_cout_d;
      r_wrap <= w_wrap_d;
    end
  end

  assign cout     = r_cout;
  assign resetOut = r_wrap;

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter: a vector table, hand-written corner
// sequences on the full-size counter, and pass-length plus randomized checks
// against a reference model on a small (LAST_ADDR=99) instance.
module tb_mode_counter;

  localparam int Last  = 22499;
  localparam int W     = 15;
  localparam int SLast = 99;
  localparam int SW    = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0, en = 1'b0;
  logic [2:0]   md = 3'd0;
  logic         pulse;
  logic [W-1:0] cout;

  logic          s_rst = 1'b0, s_en = 1'b0;
  logic [2:0]    s_md = 3'd0;
  logic          s_pulse;
  logic [SW-1:0] s_cout;

  int errors = 0;
  int checks = 0;
  int m_cout = 0;
  bit m_pulse = 1'b0;
  int s_m_cout = 0;
  bit s_m_pulse = 1'b0;
  int pulses = 0;

  mode_counter #(.LAST_ADDR(Last), .WIDTH(W)) dut (
    .clk(clk), .resetIn(rst), .mode(md), .enb(en), .resetOut(pulse), .cout(cout)
  );

  mode_counter #(.LAST_ADDR(SLast), .WIDTH(SW)) dut_s (
    .clk(clk), .resetIn(s_rst), .mode(s_md), .enb(s_en), .resetOut(s_pulse), .cout(s_cout)
  );

  typedef struct {
    bit         rst;
    bit         en;
    logic [2:0] md;
    int         exp_cout;
    bit         exp_pulse;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: one enabled step of `m` addresses on an array of last+1 entries.
  function automatic void ref_next(input int last, input bit r, input bit e, input int m,
                                   input int c, output int c_n, output bit p);
    p   = 1'b0;
    c_n = c;
    if (r) c_n = 0;
    else if (e && m != 0) begin
      if (c + m > last) begin
        c_n = 0;
        p   = 1'b1;
      end else c_n = c + m;
    end
  endfunction

  task automatic cyc_main(input bit r, input bit e, input logic [2:0] m);
    int c_n;
    bit p_n;
    rst = r; en = e; md = m;
    @(posedge clk); #1;
    ref_next(Last, r, e, int'(m), m_cout, c_n, p_n);
    m_cout = c_n; m_pulse = p_n;
    if (pulse === 1'b1) pulses++;
    check("cout", 32'(cout), 32'(m_cout));
    check("resetOut", 32'(pulse), 32'(m_pulse));
  endtask

  task automatic cyc_small(input bit r, input bit e, input logic [2:0] m);
    int c_n;
    bit p_n;
    s_rst = r; s_en = e; s_md = m;
    @(posedge clk); #1;
    ref_next(SLast, r, e, int'(m), s_m_cout, c_n, p_n);
    s_m_cout = c_n; s_m_pulse = p_n;
    if (s_pulse === 1'b1) pulses++;
    check("s_cout", 32'(s_cout), 32'(s_m_cout));
    check("s_resetOut", 32'(s_pulse), 32'(s_m_pulse));
  endtask

  task automatic reset_main();
    cyc_main(1'b1, 1'b0, 3'd0);
    pulses = 0;
  endtask

  initial begin
    vec_t vecs[10];
    int n;

    vecs[0] = '{1'b1, 1'b1, 3'd5, 0,  1'b0};
    vecs[1] = '{1'b0, 1'b1, 3'd3, 3,  1'b0};
    vecs[2] = '{1'b0, 1'b1, 3'd0, 3,  1'b0};
    vecs[3] = '{1'b0, 1'b0, 3'd5, 3,  1'b0};
    vecs[4] = '{1'b0, 1'b1, 3'd5, 8,  1'b0};
    vecs[5] = '{1'b0, 1'b1, 3'd7, 15, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 3'd7, 0,  1'b0};
    vecs[7] = '{1'b0, 1'b1, 3'd2, 2,  1'b0};
    vecs[8] = '{1'b0, 1'b1, 3'd1, 3,  1'b0};
    vecs[9] = '{1'b0, 1'b1, 3'd6, 9,  1'b0};

    // Power-up value before any clock edge.
    #1;
    check("powerup_cout", 32'(cout), 32'd0);
    check("powerup_resetOut", 32'(pulse), 32'd0);

    reset_main();
    check("reset_cout", 32'(cout), 32'd0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; md = vecs[i].md;
      @(posedge clk); #1;
      check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_resetOut", i), 32'(pulse), 32'(vecs[i].exp_pulse));
    end

    // Full pass at mode 1.
    m_cout = 0;
    reset_main();
    repeat (22500) cyc_main(1'b0, 1'b1, 3'd1);
    check("m1_wrap_cout", 32'(cout), 32'd0);
    check("m1_wrap_pulse", 32'(pulse), 32'd1);
    cyc_main(1'b0, 1'b1, 3'd1);
    check("m1_after_cout", 32'(cout), 32'd1);
    check("m1_after_pulse", 32'(pulse), 32'd0);
    check("m1_pulses", 32'(pulses), 32'd1);

    // Mode 4 last value then wrap; pulse drops on next edge.
    reset_main();
    repeat (5624) cyc_main(1'b0, 1'b1, 3'd4);
    check("m4_last", 32'(cout), 32'd22496);
    cyc_main(1'b0, 1'b1, 3'd4);
    check("m4_wrap_cout", 32'(cout), 32'd0);
    check("m4_wrap_pulse", 32'(pulse), 32'd1);
    cyc_main(1'b0, 1'b1, 3'd4);
    check("m4_after_cout", 32'(cout), 32'd4);
    check("m4_after_pulse", 32'(pulse), 32'd0);

    // Mode 7: wrap to 0, not to the remainder; pulse drops even with enb low.
    reset_main();
    repeat (3214) cyc_main(1'b0, 1'b1, 3'd7);
    check("m7_last", 32'(cout), 32'd22498);
    cyc_main(1'b0, 1'b1, 3'd7);
    check("m7_wrap_cout", 32'(cout), 32'd0);
    check("m7_wrap_pulse", 32'(pulse), 32'd1);
    cyc_main(1'b0, 1'b0, 3'd7);
    check("m7_enb_drop_pulse", 32'(pulse), 32'd0);

    // Hold via enb=0, then via mode=0.
    for (int k = 0; k < 2; k++) begin
      reset_main();
      repeat (100) cyc_main(1'b0, 1'b1, 3'd1);
      if (k == 0) repeat (50) cyc_main(1'b0, 1'b0, 3'd1);
      else        repeat (50) cyc_main(1'b0, 1'b1, 3'd0);
      check($sformatf("hold%0d_cout", k), 32'(cout), 32'd100);
      check($sformatf("hold%0d_pulses", k), 32'(pulses), 32'd0);
      cyc_main(1'b0, 1'b1, 3'd1);
      check($sformatf("hold%0d_resume", k), 32'(cout), 32'd101);
    end

    // Reset on the wrap edge suppresses the pulse.
    reset_main();
    repeat (3214) cyc_main(1'b0, 1'b1, 3'd7);
    cyc_main(1'b0, 1'b1, 3'd1);
    check("pre_wrap", 32'(cout), 32'd22499);
    cyc_main(1'b1, 1'b1, 3'd1);
    check("rst_wrap_cout", 32'(cout), 32'd0);
    check("rst_wrap_pulse", 32'(pulse), 32'd0);
    repeat (3) cyc_main(1'b0, 1'b0, 3'd0);
    check("rst_wrap_no_pulse", 32'(pulses), 32'd0);
    cyc_main(1'b0, 1'b1, 3'd2);
    check("rst_restart", 32'(cout), 32'd2);

    // Reset mid-count holds at 0 while asserted.
    reset_main();
    repeat (1250) cyc_main(1'b0, 1'b1, 3'd4);
    check("at_5000", 32'(cout), 32'd5000);
    cyc_main(1'b1, 1'b1, 3'd4);
    check("rst_5000_cout", 32'(cout), 32'd0);
    repeat (5) cyc_main(1'b1, 1'b1, 3'd4);
    check("rst_hold_cout", 32'(cout), 32'd0);

    // Mode change 1 -> 3 near the end.
    reset_main();
    repeat (3212) cyc_main(1'b0, 1'b1, 3'd7);
    repeat (6) cyc_main(1'b0, 1'b1, 3'd1);
    check("at_22490", 32'(cout), 32'd22490);
    cyc_main(1'b0, 1'b1, 3'd3);
    check("mc_22493", 32'(cout), 32'd22493);
    cyc_main(1'b0, 1'b1, 3'd3);
    check("mc_22496", 32'(cout), 32'd22496);
    cyc_main(1'b0, 1'b1, 3'd3);
    check("mc_22499", 32'(cout), 32'd22499);
    cyc_main(1'b0, 1'b1, 3'd3);
    check("mc_wrap_cout", 32'(cout), 32'd0);
    check("mc_wrap_pulse", 32'(pulse), 32'd1);

    // Small instance: 3 passes per mode, enabled-cycle count = 3*ceil(100/m).
    for (int m = 1; m <= 7; m++) begin
      cyc_small(1'b1, 1'b0, 3'd0);
      pulses = 0;
      n = 0;
      for (int t = 0; t < 2000 && pulses < 3; t++) begin
        if ($urandom_range(0, 3) == 0) cyc_small(1'b0, 1'b0, 3'(m));
        else begin
          cyc_small(1'b0, 1'b1, 3'(m));
          n++;
        end
      end
      check($sformatf("pass_len_m%0d", m), 32'(n), 32'(3 * ((SLast + 1 + m - 1) / m)));
      check($sformatf("pulses_m%0d", m), 32'(pulses), 32'd3);
    end

    // Randomized run on the small instance against the model.
    cyc_small(1'b1, 1'b0, 3'd0);
    repeat (4000) begin
      cyc_small(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
